keypad_scanner: RTL and testbench

- Column-scan controller for the 4x4 matrix keypad. It sits directly upstream of the debouncer and also consumes the debouncer's result.
- Drives active-low columns and synchronizes the raw active-low rows.
- Freezes the scan when a key is seen and hands the row pattern to the debouncer as its criterion.
- On debouncer `steady`, emits a one-cycle key event, then waits for a debounced release before it resumes scanning.

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/keypad_scanner_sync_2ff.sv | 32 +++
 rtl/keypad_scanner.sv | 216 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its helpers.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents:
//   state_t       scanner FSM states
//   KEY_W         key_code width for the standard 4x4 board
//   SETTLE_CYCLES cycles of row data ignored after each column change
//   HEX_LEGEND    board legend, indexed by row*4 + col
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam int KEY_W    = $clog2(KEY_ROWS * KEY_COLS);

  // Two cycles of synchronizer latency plus one cycle for the column
  // drive and row lines to settle after the column moves.
  localparam int SETTLE_CYCLES = 3;

  // Printed legend, row-major:
  //   1 2 3 A
  //   4 5 6 B
  //   7 8 9 C
  //   E 0 F D
  localparam logic [KEY_W-1:0] HEX_LEGEND [KEY_ROWS*KEY_COLS] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for a bus of independent, slowly changing inputs.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; samples every cycle.
//
// Ports:
//   clk    sampling clock
//   reset  asynchronous, active-low; q and the first stage load RESET_VAL
//   d      asynchronous input bus
//   q      synchronized output bus
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scan controller for a matrix keypad, paired with an external debouncer.
// Latency: key_valid one cycle after db_steady is sampled high; rows seen 2 cycles late.
// Backpressure: none; key_valid is a single-cycle pulse with no handshake.
//
// Ports:
//   clk, reset         system clock; asynchronous active-low reset
//   row                raw active-low rows (asynchronous)
//   col                active-low column drive, one-hot-low while scanning
//   db_in              synchronized rows, to the debouncer input
//   db_criterion       row pattern the debouncer must see held
//   db_period          constant debounce period (DB_CYCLES)
//   db_en / db_clr     debouncer enable / one-cycle restart pulse
//   db_steady          debouncer steady tick
//   key_code           last accepted key (raw index or board legend)
//   key_valid          one-cycle pulse per accepted key
//   key_held           high from acceptance until debounced release
//
// Build option: KEYPAD_HEX_MAP_EN translates key_code through the board
// legend (4x4 geometry only); without it key_code = row*COLS + col.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int SCAN_DIV  = 24000,
  parameter int DB_CYCLES = 480000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ROWS-1:0]              row,
  output logic [COLS-1:0]              col,
  output logic [ROWS-1:0]              db_in,
  output logic [ROWS-1:0]              db_criterion,
  output logic [31:0]                  db_period,
  output logic                         db_en,
  output logic                         db_clr,
  input  logic                         db_steady,
  output logic [$clog2(ROWS*COLS)-1:0] key_code,
  output logic                         key_valid,
  output logic                         key_held
);

  localparam int KW = $clog2(ROWS * COLS);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

`ifdef KEYPAD_HEX_MAP_EN
  if (ROWS != 4 || COLS != 4) begin : g_hex_geom_err
    $error("keypad_scanner: KEYPAD_HEX_MAP_EN requires ROWS == COLS == 4");
  end
`endif

  state_t          state, state_nxt;
  logic [ROWS-1:0] rows_s;
  logic [ROWS-1:0] criterion;
  logic [CW-1:0]   col_idx;
  logic [DW-1:0]   div_cnt;
  logic [SW-1:0]   settle_cnt;
  logic            entry;       // first cycle of DEBOUNCE or RELEASE

  logic            div_tc;
  logic            settle_done;
  logic            one_low;
  logic            rows_match;
  logic            rows_idle;
  logic            advance;
  logic            accept;
  logic [RW-1:0]   row_idx;
  logic [KW-1:0]   key_idx;
  logic [KW-1:0]   key_code_nxt;

  // ------------------------------------------------------------------
  // Row synchronizer; idle (all-ones) out of reset so no phantom key.
  // ------------------------------------------------------------------
  sync_2ff #(
    .WIDTH     (ROWS),
    .RESET_VAL ({ROWS{1'b1}})
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (rows_s)
  );

  assign db_in        = rows_s;
  assign db_criterion = criterion;
  assign db_period    = 32'(DB_CYCLES);

  // ------------------------------------------------------------------
  // Decode helpers
  // ------------------------------------------------------------------
  assign div_tc      = (div_cnt == DW'(SCAN_DIV - 1));
  assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES));
  assign one_low     = ($countones(~rows_s) == 1);
  assign rows_match  = (rows_s == criterion);
  assign rows_idle   = (rows_s == {ROWS{1'b1}});

  // Row index of the single low bit in the captured criterion.
  always_comb begin
    row_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (!criterion[i]) row_idx = RW'(i);
    end
  end

  assign key_idx = KW'(int'(row_idx) * COLS + int'(col_idx));

`ifdef KEYPAD_HEX_MAP_EN
  assign key_code_nxt = KW'(HEX_LEGEND[key_idx]);
`else
  assign key_code_nxt = key_idx;
`endif

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SCAN;
    else        state <= state_nxt;
  end

  // ------------------------------------------------------------------
  // FSM: next state. A row mismatch is checked before db_steady so an
  // abort always wins over a coincident steady tick. db_steady is
  // ignored on the entry cycle while the debouncer is being cleared.
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      SCAN: begin
        if (settle_done && one_low) state_nxt = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (!rows_match)               state_nxt = SCAN;
        else if (db_steady && !entry)  state_nxt = PRESSED;
      end
      PRESSED: begin
        if (rows_idle) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!rows_idle)                state_nxt = PRESSED;
        else if (db_steady && !entry)  state_nxt = SCAN;
      end
      default: state_nxt = SCAN;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  always_comb begin
    col    = {COLS{1'b1}};
    db_en  = 1'b0;
    db_clr = 1'b0;
    col[col_idx] = 1'b0;
    if (state == DEBOUNCE || state == RELEASE) begin
      db_clr = entry;
      db_en  = !entry;
    end
  end

  // ------------------------------------------------------------------
  // Datapath
  // ------------------------------------------------------------------
  // The column moves on a divider terminal count while scanning, and
  // also whenever DEBOUNCE or RELEASE hands control back to SCAN, so a
  // rejected or just-released key is not re-examined immediately.
  assign advance = (state == SCAN && state_nxt == SCAN && div_tc) ||
                   (state != SCAN && state_nxt == SCAN);
  assign accept  = (state == DEBOUNCE) && (state_nxt == PRESSED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_idx    <= '0;
      div_cnt    <= '0;
      settle_cnt <= '0;
      entry      <= 1'b0;
      criterion  <= {ROWS{1'b1}};
      key_code   <= '0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      entry <= (state_nxt != state) &&
               (state_nxt == DEBOUNCE || state_nxt == RELEASE);

      if (state == SCAN && state_nxt == SCAN)
        div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
      else
        div_cnt <= '0;

      if (advance)
        col_idx <= (col_idx == CW'(COLS - 1)) ? '0 : col_idx + 1'b1;

      if (advance)
        settle_cnt <= '0;
      else if (state == SCAN && !settle_done)
        settle_cnt <= settle_cnt + 1'b1;

      if (state == SCAN && state_nxt == DEBOUNCE)
        criterion <= rows_s;
      else if (state == PRESSED && state_nxt == RELEASE)
        criterion <= {ROWS{1'b1}};

      key_valid <= accept;
      if (accept) begin
        key_code <= key_code_nxt;
        key_held <= 1'b1;
      end else if (state == RELEASE && state_nxt == SCAN) begin
        key_held <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner: physical keypad model, debouncer model,
// and expected timing derived from the scan rules (8-cycle columns, 2-flop sync,
// 3 ignored cycles after a column change, steady 5 cycles after db_en rises).
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row, col, db_in, db_criterion;
  logic [31:0] db_period;
  logic        db_en, db_clr, db_steady;
  logic [3:0]  key_code;
  logic        key_valid, key_held;

  logic [15:0] keys = '0;   // pressed keys, bit r*4+c
  int          db_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int k;                     // posedges since reset release
  int n_clr, n_kv, n_steady;
  bit prev_steady, prev_kv;

  localparam logic [3:0] LEGEND [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD
  };

  keypad_scanner #(.SCAN_DIV(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .row          (row),
    .col          (col),
    .db_in        (db_in),
    .db_criterion (db_criterion),
    .db_period    (db_period),
    .db_en        (db_en),
    .db_clr       (db_clr),
    .db_steady    (db_steady),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_held     (key_held)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low whenever its column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Debouncer model: ticks on the 6th consecutive enabled, matching cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset)                                db_cnt <= 0;
    else if (!db_en || db_in != db_criterion)  db_cnt <= 0;
    else                                       db_cnt <= db_cnt + 1;
  end
  assign db_steady = db_en && (db_in == db_criterion) && (db_cnt == 5);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [3:0] col_of(input int ci);
    logic [3:0] v;
    v = 4'b1111;
    v[ci] = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0] exp_col(input int kk);
    return col_of((kk / 8) % 4);
  endfunction

  function automatic logic [3:0] exp_code(input int r, input int c);
`ifdef KEYPAD_HEX_MAP_EN
    return LEGEND[r*4+c];
`else
    return 4'(r*4 + c);
`endif
  endfunction

  // One clock; samples on the falling edge and tracks pulses.
  task automatic tick();
    @(negedge clk);
    k++;
    if (db_clr)    n_clr++;
    if (db_steady) n_steady++;
    if (key_valid) begin
      n_kv++;
      check_eq("kv_after_steady", 32'(prev_steady), 1);
      check_eq("kv_one_cycle", 32'(prev_kv), 0);
    end
    prev_steady = db_steady;
    prev_kv     = key_valid;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_col"},   col, 4'b1110);
    check_eq({tag, "_dbin"},  db_in, 4'hF);
    check_eq({tag, "_crit"},  db_criterion, 4'hF);
    check_eq({tag, "_code"},  key_code, 0);
    check_eq({tag, "_kv"},    key_valid, 0);
    check_eq({tag, "_held"},  key_held, 0);
    check_eq({tag, "_en"},    db_en, 0);
    check_eq({tag, "_clr"},   db_clr, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");
    check_eq("db_period", db_period, 480000);
    reset = 1'b1;
    k = 0; n_clr = 0; n_kv = 0; n_steady = 0;
    prev_steady = 0; prev_kv = 0;
  endtask

  task automatic press_trial(input int r, input int c, input int hold);
    int first_clr, kv_k, s0, kv0, guard;
    logic [15:0] kmask;
    kmask = 16'h1 << (r*4 + c);
    keys = kmask;
    do_reset();
    first_clr = -1;
    kv_k = -1;
    while (k < 8*c + 11) begin
      tick();
      if (db_clr && first_clr < 0) first_clr = k;
      if (key_valid && kv_k < 0)   kv_k = k;
    end
    check_eq("clr_time", first_clr, 8*c + 4);
    check_eq("kv_time", kv_k, 8*c + 11);
    check_eq("key_code", key_code, exp_code(r, c));
    check_eq("held_on_accept", key_held, 1);
    check_eq("col_frozen", col, col_of(c));
    check_eq("clr_count", n_clr, 1);
    tick();
    check_eq("kv_drops", key_valid, 0);
    repeat (hold) tick();
    check_eq("held_while_pressed", key_held, 1);
    check_eq("col_frozen_hold", col, col_of(c));
    check_eq("kv_count_hold", n_kv, 1);
    // Release with bounce.
    s0 = n_steady;
    kv0 = n_kv;
    for (int b = 0; b < 2; b++) begin
      keys = '0;
      repeat ($urandom_range(1, 2)) tick();
      keys = kmask;
      repeat ($urandom_range(1, 2)) tick();
    end
    keys = '0;
    guard = 0;
    while (key_held && guard < 60) begin
      tick();
      guard++;
    end
    check_eq("release_done", key_held, 0);
    check_eq("release_steady_cnt", n_steady - s0, 1);
    check_eq("release_no_kv", n_kv - kv0, 0);
    check_eq("col_after_release", col, col_of((c + 1) % 4));
    check_eq("code_holds", key_code, exp_code(r, c));
  endtask

  initial begin
    int r, c, guard;

    // Idle scan.
    keys = '0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      check_eq("idle_col", col, exp_col(k));
      tick();
    end
    check_eq("idle_no_kv", n_kv, 0);
    check_eq("idle_no_clr", n_clr, 0);

    // Clean press of row1/col2, then reset in the middle of DEBOUNCE.
    press_trial(1, 2, 4);
    r = $urandom_range(0, 3);
    keys = 16'h1 << (r*4);
    guard = 0;
    while (!db_clr && guard < 40) begin
      tick();
      guard++;
    end
    check_eq("mid_clr_seen", db_clr, 1);
    tick();
    tick();
    reset = 1'b0;
    keys = '0;
    tick();
    check_reset_vals("mid_rst");
    reset = 1'b1;
    k = 0; n_clr = 0; n_kv = 0; n_steady = 0;
    prev_steady = 0; prev_kv = 0;
    for (int i = 0; i < 24; i++) begin
      check_eq("post_rst_col", col, exp_col(k));
      tick();
    end
    check_eq("post_rst_no_clr", n_clr, 0);

    // Bounce abort on column 2: low for 3 cycles only.
    r = $urandom_range(0, 3);
    keys = '0;
    do_reset();
    while (k < 20) tick();
    keys = 16'h1 << (r*4 + 2);
    while (k < 23) tick();
    keys = '0;
    while (k < 26) begin
      tick();
      if (k == 24) check_eq("abort_frozen", col, 4'b1011);
    end
    check_eq("abort_col", col, 4'b0111);
    check_eq("abort_clr", n_clr, 1);
    check_eq("abort_no_kv", n_kv, 0);
    while (k < 33) tick();
    check_eq("abort_div_reset", col, 4'b0111);
    tick();
    check_eq("abort_next_col", col, 4'b1110);

    // Multi-key in one column is rejected.
    c = $urandom_range(0, 3);
    keys = (16'h1 << (4 + c)) | (16'h1 << (8 + c));
    do_reset();
    for (int i = 0; i < 40; i++) begin
      check_eq("multi_col", col, exp_col(k));
      tick();
    end
    check_eq("multi_no_clr", n_clr, 0);
    check_eq("multi_no_kv", n_kv, 0);
    keys = '0;

    // Random keys.
    for (int t = 0; t < 6; t++)
      press_trial($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(2, 10));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
